logic_unit_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational ALU logic slice.
- Performs the single-cycle bitwise operations (AND, OR, XOR, NOR, pass-A) at configurable width.
- Adds MIPS32 count-leading-zeros/ones as an iterative multi-cycle operation.
- Flags illegal function codes explicitly instead of silently returning a constant.
- Sits between the ALU operand/decode stage and the ALU result mux; uses a valid/ready handshake on both sides.

---
 rtl/logic_unit_pkg.sv | 39 +++
 rtl/logic_unit_pipe_clz_chunk.sv | 33 +++
 rtl/logic_unit_pipe.sv | 155 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pkg
// Description : Function codes, FSM state type and decode helpers shared by
//               the pipelined logic unit and its count-leading-zeros slice.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    localparam logic [3:0] FT_AND = 4'b1000;
    localparam logic [3:0] FT_OR  = 4'b1110;
    localparam logic [3:0] FT_XOR = 4'b0110;
    localparam logic [3:0] FT_NOR = 4'b0001;
    localparam logic [3:0] FT_A   = 4'b1010;
    localparam logic [3:0] FT_CLO = 4'b0010;
    localparam logic [3:0] FT_CLZ = 4'b0011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // True for every function code the unit implements.
    function automatic logic is_legal_ft(input logic [3:0] ft);
        logic legal;
        case (ft)
            FT_AND, FT_OR, FT_XOR, FT_NOR, FT_A, FT_CLO, FT_CLZ: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for the iterative (multi-cycle) leading-bit count operations.
    function automatic logic is_count_ft(input logic [3:0] ft);
        return (ft == FT_CLO) || (ft == FT_CLZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_clz_chunk.sv
`default_nettype none
// ============================================================================
// Module      : clz_chunk
// Description : Combinational leading-zero count of one CHUNK-bit slice,
//               plus a flag saying whether the slice holds any set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module clz_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]         chunk,
    output logic [$clog2(CHUNK):0]   lz,
    output logic                     any_one
);

    localparam int CW = $clog2(CHUNK) + 1;

    // Scan MSB-first; the first set bit fixes the count, an empty slice counts CHUNK.
    always_comb begin
        logic w_found;
        lz      = CW'(CHUNK);
        w_found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!w_found && chunk[i]) begin
                lz      = CW'(CHUNK - 1 - i);
                w_found = 1'b1;
            end
        end
        any_one = |chunk;
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Handshaked bitwise logic unit (AND/OR/XOR/NOR/pass-A) with
//               single-cycle latency, plus fixed-latency iterative CLZ/CLO
//               that examines CHUNK bits per cycle. Illegal function codes
//               return ERROR_VALUE with out_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          CHUNK       = 8,
    parameter int unsigned ERROR_VALUE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_ft,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_err
);

    localparam int K  = WIDTH / CHUNK;
    localparam int CW = $clog2(CHUNK) + 1;
    localparam int AW = $clog2(WIDTH) + 1;
    localparam int NW = (K > 1) ? $clog2(K) : 1;

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_shadow,    w_shadow_nxt;
    logic [NW-1:0]    r_cnt,       w_cnt_nxt;
    logic [AW-1:0]    r_acc,       w_acc_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_s,     w_out_s_nxt;
    logic             r_out_err,   w_out_err_nxt;

    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_logic_res;
    logic [CW-1:0]    w_lz;
    logic             w_any_one;
    logic [AW-1:0]    w_acc_sum;

    // Only the top chunk of the shadow is inspected; the shadow shifts up each COUNT edge.
    clz_chunk #(
        .CHUNK (CHUNK)
    ) u_clz_chunk (
        .chunk   (r_shadow[WIDTH-1 -: CHUNK]),
        .lz      (w_lz),
        .any_one (w_any_one)
    );

    // Ready only when idle, out of reset, and the output slot is free or draining now.
    assign in_ready  = rst_n && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = r_out_valid && out_ready;
    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_err   = r_out_err;

    // Single-cycle result mux; anything unrecognised yields the error constant.
    always_comb begin
        w_logic_res = WIDTH'(ERROR_VALUE);
        case (in_ft)
            FT_AND:  w_logic_res = in_a & in_b;
            FT_OR:   w_logic_res = in_a | in_b;
            FT_XOR:  w_logic_res = in_a ^ in_b;
            FT_NOR:  w_logic_res = ~(in_a | in_b);
            FT_A:    w_logic_res = in_a;
            default: w_logic_res = WIDTH'(ERROR_VALUE);
        endcase
    end

    // Accumulate the chunk count only until the first set bit has been seen.
    assign w_acc_sum = r_done ? r_acc : (r_acc + AW'(w_lz));

    // Next-state and datapath update for the IDLE/COUNT controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_done_nxt      = r_done;
        w_out_valid_nxt = r_out_valid;
        w_out_s_nxt     = r_out_s;
        w_out_err_nxt   = r_out_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_count_ft(in_ft)) begin
                        // CLO is CLZ of the inverted operand.
                        w_shadow_nxt    = (in_ft == FT_CLO) ? ~in_a : in_a;
                        w_cnt_nxt       = '0;
                        w_acc_nxt       = '0;
                        w_done_nxt      = 1'b0;
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = COUNT;
                    end else begin
                        w_out_s_nxt     = w_logic_res;
                        w_out_err_nxt   = !is_legal_ft(in_ft);
                        w_out_valid_nxt = 1'b1;
                    end
                end else if (w_xfer) begin
                    w_out_valid_nxt = 1'b0;
                end
            end
            COUNT: begin
                // Always K edges, no early exit, so latency is data-independent.
                w_acc_nxt    = w_acc_sum;
                w_done_nxt   = r_done | w_any_one;
                w_shadow_nxt = r_shadow << CHUNK;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == NW'(K - 1)) begin
                    w_out_s_nxt     = WIDTH'(w_acc_sum);
                    w_out_err_nxt   = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_done      <= w_done_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_s     <= w_out_s_nxt;
            r_out_err   <= w_out_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe (WIDTH=32, CHUNK=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [3:0]   in_ft = 4'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_s;
    logic         out_err;

    int total = 0;
    int bad   = 0;

    logic_unit_pipe #(
        .WIDTH       (W),
        .CHUNK       (8),
        .ERROR_VALUE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ft     (in_ft),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] lead_zeros(input logic [W-1:0] v);
        int n = 0;
        while (n < W && v[W-1-n] == 1'b0) n++;
        return W'(n);
    endfunction

    function automatic void model(input logic [3:0] ft, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic e);
        e = 1'b0;
        case (ft)
            4'b1000: s = a & b;
            4'b1110: s = a | b;
            4'b0110: s = a ^ b;
            4'b0001: s = ~(a | b);
            4'b1010: s = a;
            4'b0011: s = lead_zeros(a);
            4'b0010: s = lead_zeros(~a);
            default: begin s = 1; e = 1'b1; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_s !== '0) begin bad++; $display("FAIL reset_out_s got=%h want=0", out_s); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_and();
        in_valid = 1'b1; in_ft = 4'b1000; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_FFFF;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL and_valid got=%b want=1", out_valid); end
        total++; if (out_s !== 32'h00F0_1234) begin bad++; $display("FAIL and_s got=%h want=00f01234", out_s); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL and_err got=%b want=0", out_err); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL and_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   fts [4] = '{4'b1110, 4'b0110, 4'b0001, 4'b1010};
        logic [W-1:0] exp [4] = '{32'h3, 32'h3, 32'hFFFF_FFFC, 32'h1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_ft = fts[i]; in_a = 32'h1; in_b = 32'h2;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_s !== exp[i] || out_err !== 1'b0) begin
                bad++; $display("FAIL b2b_result[%0d] got=%b/%h/%b want=1/%h/0", i, out_valid, out_s, out_err, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_count(input logic [3:0] ft, input logic [W-1:0] a);
        logic [W-1:0] es; logic ee;
        model(ft, a, '0, es, ee);
        out_ready = 1'b1;
        in_valid = 1'b1; in_ft = ft; in_a = a; in_b = $urandom;
        tick();
        in_valid = 1'b0; in_a = $urandom;
        for (int j = 1; j <= 4; j++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL count_busy[%0d] ft=%b ready=%b valid=%b want=0/0", j, ft, in_ready, out_valid);
            end
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_s !== es || out_err !== 1'b0) begin
            bad++; $display("FAIL count_result ft=%b a=%h got=%b/%0d/%b want=1/%0d/0", ft, a, out_valid, out_s, out_err, es);
        end
        tick();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_ft = 4'b0100; in_a = $urandom; in_b = $urandom;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_s !== 32'h1 || out_err !== 1'b1) begin
            bad++; $display("FAIL illegal got=%b/%h/%b want=1/00000001/1", out_valid, out_s, out_err);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held, es; logic ee;
        out_ready = 1'b0;
        in_valid = 1'b1; in_ft = 4'b0110; in_a = $urandom; in_b = $urandom;
        model(in_ft, in_a, in_b, held, ee);
        tick();
        in_ft = 4'b1110; in_a = $urandom; in_b = $urandom;
        model(in_ft, in_a, in_b, es, ee);
        for (int j = 0; j < 5; j++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_s !== held) begin
                bad++; $display("FAIL bp_hold[%0d] ready=%b valid=%b s=%h want=0/1/%h", j, in_ready, out_valid, out_s, held);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_s !== es) begin
            bad++; $display("FAIL bp_next got=%b/%h want=1/%h", out_valid, out_s, es);
        end
        tick();
    endtask

    task automatic test_reset_mid_count();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ft = 4'b0011; in_a = 32'h0000_0100;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_async valid=%b ready=%b want=0/0", out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL midrst_after[%0d] valid=%b ready=%b want=0/1", j, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]   legal [7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b1010, 4'b0010, 4'b0011};
        logic [W-1:0] qs [$];
        logic         qe [$];
        logic [W-1:0] es, prev_s;
        logic         ee, prev_hold;
        int           drain;
        prev_hold = 1'b0; prev_s = '0;
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ft     = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 6)] : 4'($urandom);
            case ($urandom_range(0, 3))
                0: in_a = $urandom;
                1: in_a = '0;
                2: in_a = '1;
                default: in_a = 32'($urandom) >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) in_a = ~in_a;
            in_b      = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_hold) begin
                total++; if (out_valid !== 1'b1 || out_s !== prev_s) begin
                    bad++; $display("FAIL rnd_hold c=%0d valid=%b s=%h want=1/%h", c, out_valid, out_s, prev_s);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (qs.size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected c=%0d got=%h want=none", c, out_s);
                end else begin
                    es = qs.pop_front(); ee = qe.pop_front();
                    if (out_s !== es || out_err !== ee) begin
                        bad++; $display("FAIL rnd_result c=%0d got=%h/%b want=%h/%b", c, out_s, out_err, es, ee);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(in_ft, in_a, in_b, es, ee);
                qs.push_back(es); qe.push_back(ee);
            end
            prev_hold = out_valid && !out_ready;
            prev_s    = out_s;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain = 0;
        while ((qs.size() != 0 || out_valid) && drain < 40) begin
            #1;
            if (out_valid) begin
                total++;
                if (qs.size() == 0) begin
                    bad++; $display("FAIL rnd_drain_unexpected got=%h", out_s);
                end else begin
                    es = qs.pop_front(); ee = qe.pop_front();
                    if (out_s !== es || out_err !== ee) begin
                        bad++; $display("FAIL rnd_drain got=%h/%b want=%h/%b", out_s, out_err, es, ee);
                    end
                end
            end
            @(posedge clk); #1;
            drain++;
        end
        total++; if (qs.size() != 0) begin
            bad++; $display("FAIL rnd_timeout pending=%0d want=0", qs.size());
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_count(4'b0011, 32'h00F0_0000);
        test_count(4'b0011, 32'h0000_0000);
        test_count(4'b0010, 32'hFFFF_0000);
        test_count(4'b0011, 32'h8000_0000);
        test_count(4'b0010, 32'hFFFF_FFFF);
        test_count(4'b0011, 32'h0000_0001);
        test_illegal();
        test_backpressure();
        test_reset_mid_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
